iob_ibus_dbus_arbiter: RTL and testbench
========================================

// Module: iob_ibus_dbus_arbiter
// PURPOSE
//  2:1 arbiter that merges the CPU instruction bus (ibus) and data bus (dbus) onto one
//  IOb native memory port. Used when both buses share one memory or peripheral slave.
//  Arbitrates requests round-robin and locks the grant through each handshake.
//  Tracks up to OUTS_DEPTH accepted reads in an owner FIFO so each in-order rvalid/rdata
//  response returns to the requester that issued it.
// PARAMETERS
//  ADDR_W      32  address width, all buses
//  DATA_W      32  data width, all buses; wstrb width is DATA_W/8
//  OUTS_DEPTH  4   max in-flight reads; power of 2, >=2
// PORTS
//  clk_i       in   1         clock, rising edge
//  cke_i       in   1         clock enable; 0 freezes all state
//  arst_i      in   1         reset; synchronous, active-high, sampled on clk_i rising edge
//  i_valid_i   in   1         ibus request valid (reads only)
//  i_addr_i    in   ADDR_W    ibus address
//  i_ready_o   out  1         ibus request accepted this cycle
//  i_rdata_o   out  DATA_W    ibus read data
//  i_rvalid_o  out  1         ibus read data valid
//  d_valid_i   in   1         dbus request valid
//  d_addr_i    in   ADDR_W    dbus address
//  d_wdata_i   in   DATA_W    dbus write data
//  d_wstrb_i   in   DATA_W/8  dbus byte strobes; 0 = read
//  d_ready_o   out  1         dbus request accepted this cycle
//  d_rdata_o   out  DATA_W    dbus read data
//  d_rvalid_o  out  1         dbus read data valid
//  m_valid_o   out  1         memory request valid
//  m_addr_o    out  ADDR_W    memory address
//  m_wdata_o   out  DATA_W    memory write data; 0 for ibus grants
//  m_wstrb_o   out  DATA_W/8  memory strobes; 0 for ibus grants
//  m_ready_i   in   1         memory accepts request
//  m_rdata_i   in   DATA_W    memory read data
//  m_rvalid_i  in   1         memory read data valid; in order, >=1 cycle after acceptance
//  err_o       out  1         sticky: rvalid received with no read outstanding
// BEHAVIOUR
//  Reset values: m_valid_o=0, i_/d_ready_o=0, i_/d_rvalid_o=0, err_o=0.
//   Owner FIFO is empty, lock is cleared, last_grant=DBUS (ibus wins first tie).
//  Grant selection (combinational, state is registered):
//   - lock set: grant = locked owner
//   - else one requester valid: grant = that requester
//   - else both valid: grant = requester that is not last_grant
//   - else: no grant
//  m_valid_o = granted valid & ~full. The m_* request fields mux from the granted source.
//  Acceptance: accept = m_valid_o & m_ready_i. Granted x_ready_o = accept; other ready = 0.
//   Zero added latency: ready is combinational from m_ready_i.
//  Lock: set when m_valid_o=1 & m_ready_i=0; holds owner; cleared on accept.
//   Grant never switches while a request is presented but not accepted.
//  last_grant: updates to the granted owner on every accept.
//  Read tracking: accept with wstrb==0 (every ibus request, dbus reads) pushes owner bit.
//   Writes push nothing and get no rvalid.
//  Response: m_rvalid_i pops FIFO head; head=IBUS gives i_rvalid_o=1, else d_rvalid_o=1.
//   Combinational, same cycle as m_rvalid_i. m_rdata_i fans out to both rdata outputs.
//  Count: ptr widths are $clog2(OUTS_DEPTH)+1 and wrap naturally.
//   full when count==OUTS_DEPTH; empty when count==0.
//  Full: m_valid_o forced 0 even if a pop occurs the same cycle. Lock is not set in that case.
//  Push and pop in the same cycle (not full): both occur; count unchanged.
//  Pop when empty: no rvalid to either side; err_o set until reset; count stays 0.
//  cke_i=0: FIFO, lock, last_grant and err_o hold. Combinational outputs still follow inputs,
//   but accept/pop have no state effect.
//  arst_i mid-transaction: everything returns to reset values next edge. In-flight responses
//   arriving later are reported by err_o.
// TESTING
//  1 Reset: arst_i=1 two cycles, random inputs -> m_valid_o=0, all rvalid=0, err_o=0.
//  2 Contention: i_valid=d_valid=1 (d read), m_ready=1 -> grants IBUS, DBUS, IBUS, DBUS
//    on consecutive cycles.
//  3 Lock: d write @0x100, m_ready=0 3 cycles, i_valid rises cycle 1 -> m_addr_o stays
//    0x100 until accept. Next grant is IBUS; write causes no push.
//  4 Routing: accept I@0x0, D-read@0x4, I@0x8; return rvalid with 0xA,0xB,0xC ->
//    i_rvalid data 0xA, d_rvalid 0xB, i_rvalid 0xC; FIFO empty.
//  5 Full: OUTS_DEPTH=4, 4 reads accepted with no response -> m_valid_o=0, i_ready_o=0
//    with i_valid=1; one rvalid -> next cycle request accepted again.
//  6 Spurious: m_rvalid_i=1 with FIFO empty -> err_o=1 and stays 1; no rvalid to ibus/dbus.

Source files
------------

// File: rtl/iob_ibus_dbus_arbiter.sv
// 2:1 round-robin arbiter merging the CPU instruction bus (ibus) and data bus
// (dbus) onto a single IOb native memory port. The grant is held while a
// request waits for m_ready_i, and an owner FIFO records who issued each
// accepted read so in-order responses are routed back to the right requester.
module iob_ibus_dbus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                i_valid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_ready_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_rvalid_o,
  input  logic                d_valid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_ready_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_rvalid_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  output logic                err_o
);

  localparam int IDX_W = $clog2(OUTS_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Owner encoding, also used for the lock owner and last_grant
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic                  lock_q, lock_d;
  logic                  lock_own_q, lock_own_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [OUTS_DEPTH-1:0] own_fifo_q, own_fifo_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W-1:0]      count;

  logic full, empty;
  logic gnt_req, gnt_own, gnt_read;
  logic accept, push, pop, head_own;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign count = wptr_q - rptr_q;
  assign full  = (count == PTR_W'(OUTS_DEPTH));
  assign empty = (count == '0);

  // Grant selection: locked owner first, then single requester, then round-robin
  always_comb begin
    gnt_own = OWN_I;
    gnt_req = 1'b0;
    if (lock_q) begin
      gnt_own = lock_own_q;
      gnt_req = (lock_own_q == OWN_I) ? i_valid_i : d_valid_i;
    end else if (i_valid_i && d_valid_i) begin
      gnt_own = (last_q == OWN_I) ? OWN_D : OWN_I;
      gnt_req = 1'b1;
    end else if (i_valid_i) begin
      gnt_own = OWN_I;
      gnt_req = 1'b1;
    end else if (d_valid_i) begin
      gnt_own = OWN_D;
      gnt_req = 1'b1;
    end
  end

  assign gnt_read  = (gnt_own == OWN_I) | (d_wstrb_i == '0);

  // Reset also masks the request so the port stays quiet while arst_i is high
  assign m_valid_o = gnt_req & ~full & ~arst_i;
  assign m_addr_o  = (gnt_own == OWN_I) ? i_addr_i : d_addr_i;
  assign m_wdata_o = (gnt_own == OWN_I) ? '0 : d_wdata_i;
  assign m_wstrb_o = (gnt_own == OWN_I) ? '0 : d_wstrb_i;

  assign accept    = m_valid_o & m_ready_i;
  assign i_ready_o = accept & (gnt_own == OWN_I);
  assign d_ready_o = accept & (gnt_own == OWN_D);
  assign push      = accept & gnt_read;

  assign head_own   = own_fifo_q[rptr_q[IDX_W-1:0]];
  assign pop        = m_rvalid_i & ~empty & ~arst_i;
  assign i_rvalid_o = pop & (head_own == OWN_I);
  assign d_rvalid_o = pop & (head_own == OWN_D);
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;
  assign err_o      = err_q;

  // Next-state for lock, round-robin history, owner FIFO and error flag
  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    last_d     = last_q;
    err_d      = err_q;
    own_fifo_d = own_fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (accept) begin
      lock_d = 1'b0;
      last_d = gnt_own;
    end else if (m_valid_o && !m_ready_i) begin
      lock_d     = 1'b1;
      lock_own_d = gnt_own;
    end
    if (push) begin
      own_fifo_d[wptr_q[IDX_W-1:0]] = gnt_own;
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    if (m_rvalid_i && empty) begin
      err_d = 1'b1;
    end
  end

  // State registers: synchronous reset has priority, cke_i gates every update
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_I;
      last_q     <= OWN_D;
      err_q      <= 1'b0;
      own_fifo_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else if (cke_i) begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      last_q     <= last_d;
      err_q      <= err_d;
      own_fifo_q <= own_fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

endmodule

// File: tb/tb_iob_ibus_dbus_arbiter.sv
// Self-checking bench for iob_ibus_dbus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_iob_ibus_dbus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int OI     = 0;
  localparam int OD     = 1;

  logic                clk, cke, arst;
  logic                i_valid, i_ready, i_rvalid;
  logic [ADDR_W-1:0]   i_addr;
  logic [DATA_W-1:0]   i_rdata;
  logic                d_valid, d_ready, d_rvalid;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata, d_rdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                m_valid, m_ready, m_rvalid, err;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata, m_rdata;
  logic [DATA_W/8-1:0] m_wstrb;

  iob_ibus_dbus_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .OUTS_DEPTH(DEPTH)
  ) dut (
    .clk_i     (clk),
    .cke_i     (cke),
    .arst_i    (arst),
    .i_valid_i (i_valid),
    .i_addr_i  (i_addr),
    .i_ready_o (i_ready),
    .i_rdata_o (i_rdata),
    .i_rvalid_o(i_rvalid),
    .d_valid_i (d_valid),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .d_wstrb_i (d_wstrb),
    .d_ready_o (d_ready),
    .d_rdata_o (d_rdata),
    .d_rvalid_o(d_rvalid),
    .m_valid_o (m_valid),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_wstrb_o (m_wstrb),
    .m_ready_i (m_ready),
    .m_rdata_i (m_rdata),
    .m_rvalid_i(m_rvalid),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: outstanding-read owners in issue order plus arbitration history
  int q[$];
  int last_own = OD;
  bit lk       = 1'b0;
  int lk_own   = OI;
  bit err_m    = 1'b0;
  bit e_acc;
  int e_own;

  task automatic model_reset();
    q.delete();
    last_own = OD;
    lk       = 1'b0;
    lk_own   = OI;
    err_m    = 1'b0;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ia, input bit dv, input logic [31:0] da,
                       input logic [31:0] dw, input logic [3:0] ds, input bit mr, input bit mrv,
                       input logic [31:0] mrd);
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da; d_wdata = dw; d_wstrb = ds;
    m_ready = mr; m_rvalid = mrv; m_rdata = mrd;
  endtask

  // One clock: compare every output with the model, then advance the model at the edge
  task automatic cycle();
    int own;
    bit gv, full, mv, acc, rd, pop, emp;
    #1;
    full = (q.size() == DEPTH);
    emp  = (q.size() == 0);
    if (lk) begin
      own = lk_own;
      gv  = (own == OI) ? i_valid : d_valid;
    end else if (i_valid && d_valid) begin
      own = (last_own == OD) ? OI : OD;
      gv  = 1'b1;
    end else if (i_valid) begin
      own = OI; gv = 1'b1;
    end else if (d_valid) begin
      own = OD; gv = 1'b1;
    end else begin
      own = OI; gv = 1'b0;
    end
    mv  = gv && !full && !arst;
    acc = mv && m_ready;
    rd  = (own == OI) || (d_wstrb == 4'h0);
    pop = m_rvalid && !emp && !arst;
    check("m_valid", m_valid, mv);
    check("i_ready", i_ready, acc && own == OI);
    check("d_ready", d_ready, acc && own == OD);
    check("i_rvalid", i_rvalid, pop && q[0] == OI);
    check("d_rvalid", d_rvalid, pop && q[0] == OD);
    check("err", err, err_m);
    if (mv) begin
      check("m_addr", m_addr, (own == OI) ? i_addr : d_addr);
      check("m_wdata", m_wdata, (own == OI) ? 32'h0 : d_wdata);
      check("m_wstrb", m_wstrb, (own == OI) ? 4'h0 : d_wstrb);
    end
    if (pop) check("rdata", (q[0] == OI) ? i_rdata : d_rdata, m_rdata);
    e_acc = acc && cke && !arst;
    e_own = own;
    @(posedge clk);
    if (arst) model_reset();
    else if (cke) begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        last_own = own;
        lk       = 1'b0;
        if (rd) q.push_back(own);
      end else if (mv && !m_ready) begin
        lk     = 1'b1;
        lk_own = own;
      end
      if (m_rvalid && emp) err_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * DEPTH && q.size() > 0; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
      cycle();
    end
    check("drained", q.size(), 0);
  endtask

  bit iv, dv;
  logic [31:0] ia, da, dw;
  logic [3:0] ds;

  initial begin
    cke  = 1'b1;
    arst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles under random inputs
    for (int k = 0; k < 2; k++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      check("rst_err", err, 0);
      cycle();
    end
    arst = 1'b0;
    model_reset();

    // Contention: alternate starting with ibus
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h1000 + k, 1, 32'h2000 + k, 0, 0, 1, 0, 0);
      #1;
      check("cont_i_ready", i_ready, (k % 2) == 0);
      check("cont_d_ready", d_ready, (k % 2) == 1);
      cycle();
    end
    drain();

    // Lock: dbus write stalled three cycles while ibus starts requesting
    for (int k = 0; k < 4; k++) begin
      drive(k >= 1, 32'h40, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, k == 3, 0, 0);
      #1;
      check("lock_addr", m_addr, 32'h100);
      check("lock_i_ready", i_ready, 0);
      cycle();
    end
    drive(1, 32'h40, 0, 0, 0, 0, 1, 0, 0);
    #1;
    check("lock_next_ibus", i_ready, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    #1;
    check("lock_only_ibus_rsp", i_rvalid, 1);
    cycle();

    // Routing of in-order responses
    drive(1, 32'h0, 0, 0, 0, 0, 1, 0, 0); cycle();
    drive(0, 0, 1, 32'h4, 0, 0, 1, 0, 0); cycle();
    drive(1, 32'h8, 0, 0, 0, 0, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
    #1; check("route_a", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hA}); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
    #1; check("route_b", {i_rvalid, d_rvalid, d_rdata}, {2'b01, 32'hB}); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hC);
    #1; check("route_c", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hC}); cycle();
    check("route_empty", q.size(), 0);

    // Full: four outstanding reads block a fifth, even across a same-cycle pop
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 32'h10 * k, 0, 0, 0, 0, 1, 0, 0);
      cycle();
    end
    drive(1, 32'h80, 0, 0, 0, 0, 1, 0, 0);
    #1; check("full_m_valid", m_valid, 0); check("full_i_ready", i_ready, 0); cycle();
    drive(1, 32'h80, 0, 0, 0, 0, 1, 1, 32'h77);
    #1; check("full_pop_m_valid", m_valid, 0); check("full_pop_rvalid", i_rvalid, 1); cycle();
    drive(1, 32'h80, 0, 0, 0, 0, 1, 0, 0);
    #1; check("full_reaccept", i_ready, 1); cycle();
    drain();

    // Randomized traffic with requesters that hold until accepted
    iv = 0; dv = 0; ia = 0; da = 0; dw = 0; ds = 0;
    for (int k = 0; k < 600; k++) begin
      if (!iv && ($urandom % 2 == 0)) begin iv = 1; ia = $urandom; end
      if (!dv && ($urandom % 2 == 0)) begin
        dv = 1; da = $urandom; dw = $urandom;
        ds = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      end
      cke = ($urandom % 8 != 0);
      drive(iv, ia, dv, da, dw, ds, ($urandom % 3 != 0), (q.size() > 0) && ($urandom % 3 == 0), $urandom);
      cycle();
      if (e_acc && e_own == OI) iv = 0;
      if (e_acc && e_own == OD) dv = 0;
    end
    cke = 1'b1;
    drain();

    // Spurious response sets a sticky error
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    #1; check("spur_rvalid", {i_rvalid, d_rvalid}, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check("spur_err_sticky", err, 1); cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
